// File: rtl/strobe_interval_meter.sv
// strobe_interval_meter: counts enable ticks between strobe_in pulses and reports each interval through a valid/ready register
module strobe_interval_meter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] interval,
  output logic             out_valid,
  output logic             overflow,
  output logic             dropped,
  output logic             armed
);
  typedef enum logic [1:0] {IDLE, MEASURE, SAT} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             w_tick_ovf;
  logic             w_cap;
  logic [WIDTH-1:0] w_sum;
  assign w_tick_ovf = (&r_count) && enable;
  assign w_sum      = w_tick_ovf ? r_count : r_count + WIDTH'(enable);
  assign w_cap      = strobe_in && (r_state != IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      interval  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      if (strobe_in) begin
        r_state <= MEASURE;
        r_count <= '0;
        armed   <= 1'b1;
      end else if (r_state == MEASURE) begin
        r_state <= w_tick_ovf ? SAT : MEASURE;
        r_count <= w_sum;
      end
      // the tick of the strobe cycle itself belongs to the window being closed
      if (w_cap) begin
        interval  <= w_sum;
        overflow  <= (r_state == SAT) || w_tick_ovf;
        dropped   <= out_valid && !out_ready;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_strobe_interval_meter.sv
// tb_strobe_interval_meter: scenario tasks plus a randomized run, all checked against a tick-counting reference model
module tb_strobe_interval_meter;
  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 0, rst = 0, enable = 0, strobe_in = 0, out_ready = 0;
  logic [W-1:0] interval;
  logic out_valid, overflow, dropped, armed;
  int checks = 0, errors = 0;
  // reference model: unbounded tick count since last strobe, result clipped on capture
  int   m_ticks = 0;
  bit   m_armed = 0, m_valid = 0, m_ovf = 0, m_drop = 0;
  int   m_int = 0;

  strobe_interval_meter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .strobe_in(strobe_in), .out_ready(out_ready),
    .interval(interval), .out_valid(out_valid), .overflow(overflow), .dropped(dropped), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic cyc(input bit s, input bit e, input bit rd, input bit r);
    int total;
    strobe_in = s; enable = e; out_ready = rd; rst = r;
    @(posedge clk);
    if (r) begin
      m_ticks = 0; m_armed = 0; m_valid = 0; m_ovf = 0; m_drop = 0; m_int = 0;
    end else begin
      if (s && m_armed) begin
        total  = m_ticks + int'(e);
        m_drop = m_valid && !rd;
        m_int  = total > MAXV ? MAXV : total;
        m_ovf  = total > MAXV;
        m_valid = 1;
      end else if (m_valid && rd) m_valid = 0;
      if (s) begin
        m_ticks = 0; m_armed = 1;
      end else if (m_armed) m_ticks += int'(e);
    end
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 1, 1, 1);
    checks++; if (interval !== 0) begin errors++; $display("FAIL reset_interval got %0d want 0", interval); end
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (overflow !== 0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (dropped !== 0) begin errors++; $display("FAIL reset_dropped got %b want 0", dropped); end
    checks++; if (armed !== 0) begin errors++; $display("FAIL reset_armed got %b want 0", armed); end
  endtask

  task automatic test_period5;
    int results = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(i % 5 == 0, 1, 1, 0);
      checks++;
      if ({interval, overflow, dropped, out_valid, armed} !== {m_int[W-1:0], m_ovf, m_drop, m_valid, m_armed}) begin
        errors++; $display("FAIL period5 cyc %0d got i=%0d o=%b d=%b v=%b a=%b want i=%0d o=%b d=%b v=%b a=%b",
          i, interval, overflow, dropped, out_valid, armed, m_int, m_ovf, m_drop, m_valid, m_armed);
      end
      if (i == 0) begin
        checks++; if (out_valid !== 0 || armed !== 1) begin errors++; $display("FAIL period5_arm got v=%b a=%b want v=0 a=1", out_valid, armed); end
      end
      if (out_valid) begin
        results++;
        checks++; if ({interval, overflow, dropped} !== {4'd5, 1'b0, 1'b0}) begin errors++; $display("FAIL period5_value got i=%0d o=%b d=%b want 5 0 0", interval, overflow, dropped); end
      end
    end
    checks++; if (results != 4) begin errors++; $display("FAIL period5_count got %0d want 4", results); end
  endtask

  task automatic test_toggle;
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 33; i++) begin
      cyc(i % 8 == 0, i % 2 == 0, 1, 0);
      if (out_valid) begin
        checks++; if ({interval, overflow} !== {4'd4, 1'b0}) begin errors++; $display("FAIL toggle got i=%0d o=%b want 4 0", interval, overflow); end
      end
    end
  endtask

  task automatic test_saturate;
    cyc(0, 0, 1, 1);
    for (int i = 0; i <= 26; i++) begin
      cyc(i == 0 || i == 20 || i == 26, 1, 1, 0);
      if (i == 20) begin
        checks++; if ({out_valid, interval, overflow} !== {1'b1, 4'd15, 1'b1}) begin errors++; $display("FAIL sat got v=%b i=%0d o=%b want 1 15 1", out_valid, interval, overflow); end
      end
      if (i == 26) begin
        checks++; if ({out_valid, interval, overflow} !== {1'b1, 4'd6, 1'b0}) begin errors++; $display("FAIL sat_next got v=%b i=%0d o=%b want 1 6 0", out_valid, interval, overflow); end
      end
    end
  endtask

  task automatic test_dropped;
    cyc(0, 0, 0, 1);
    for (int i = 0; i <= 10; i++) begin
      cyc(i == 0 || i == 3 || i == 10, 1, 0, 0);
      if (i == 3) begin
        checks++; if ({out_valid, interval, dropped} !== {1'b1, 4'd3, 1'b0}) begin errors++; $display("FAIL drop_first got v=%b i=%0d d=%b want 1 3 0", out_valid, interval, dropped); end
      end
      if (i > 3 && i < 10) begin
        checks++; if ({out_valid, interval} !== {1'b1, 4'd3}) begin errors++; $display("FAIL drop_hold got v=%b i=%0d want 1 3", out_valid, interval); end
      end
    end
    checks++; if ({out_valid, interval, dropped} !== {1'b1, 4'd7, 1'b1}) begin errors++; $display("FAIL drop_second got v=%b i=%0d d=%b want 1 7 1", out_valid, interval, dropped); end
    cyc(0, 1, 1, 0);
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL drop_accept got v=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    cyc(0, 0, 1, 1);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 1, 0);
      checks++; if ({out_valid, interval, dropped, overflow} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b got v=%b i=%0d d=%b o=%b want 1 1 0 0", out_valid, interval, dropped, overflow); end
    end
    cyc(1, 0, 1, 0);
    checks++; if ({out_valid, interval} !== {1'b1, 4'd0}) begin errors++; $display("FAIL b2b_zero got v=%b i=%0d want 1 0", out_valid, interval); end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    checks++; if ({interval, out_valid, overflow, dropped, armed} !== 8'd0) begin errors++; $display("FAIL rstmid got i=%0d v=%b o=%b d=%b a=%b want all 0", interval, out_valid, overflow, dropped, armed); end
    cyc(1, 1, 1, 0);
    checks++; if ({out_valid, armed} !== 2'b01) begin errors++; $display("FAIL rstmid_rearm got v=%b a=%b want 0 1", out_valid, armed); end
  endtask

  task automatic test_random;
    bit s, e, rd, r;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 5) == 0) || ($urandom_range(0, 40) == 0 && i % 7 == 0);
      e = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, 2) != 0;
      r = $urandom_range(0, 99) == 0;
      if (i % 300 < 40 && i % 300 > 0) s = (i % 300 == 39);
      cyc(s, e, rd, r);
      checks++;
      if ({interval, overflow, dropped, out_valid, armed} !== {m_int[W-1:0], m_ovf, m_drop, m_valid, m_armed}) begin
        errors++; $display("FAIL random cyc %0d got i=%0d o=%b d=%b v=%b a=%b want i=%0d o=%b d=%b v=%b a=%b",
          i, interval, overflow, dropped, out_valid, armed, m_int, m_ovf, m_drop, m_valid, m_armed);
      end
    end
  endtask

  initial begin
    test_reset;
    test_period5;
    test_toggle;
    test_saturate;
    test_dropped;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
